id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 5-stage RISC-V core. It captures the decode-stage control bundle (ALUOp, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite) together with operands, immediate, register indices and PC, and presents them to EX one cycle later. It also detects load-use hazards, inserts bubbles, handles branch flushes, and keeps saturating stall/flush performance counters.

## Interface
- XLEN, 64, datapath width (PC, register data, immediate)
- CNT_W, 32, performance counter width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  2  ALUOp from decode control
- id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  decode control bits
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decode datapath values
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_funct  in  4  {instr[30], instr[14:12]}
- flush  in  1  branch taken in EX/MEM; discard ID contents
- stall  out  1  load-use hazard; hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_alu_op, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  out  2/1  registered control
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered datapath
- ex_rs1, ex_rs2, ex_rd  out  5 each; ex_funct  out  4
- stall_count, flush_count  out  CNT_W each  saturating event counters

## Operation
- Load-use hazard: ex_valid & ex_mem_read & ex_rd≠0 & id_valid & (ex_rd==id_rs1 | (uses_rs2 & ex_rd==id_rs2)).
- uses_rs2 = ~id_alu_src | id_mem_write (R-type, branch, store); I-type and loads never compare rs2.
- stall = hazard & ~flush. Flush overrides stall, because the stalled instruction is being discarded anyway.
- Each rising edge, with priority reset > flush > stall > normal:
  - reset: all outputs 0.
  - flush or stall: bubble. ex_valid=0 and all seven control outputs = 0. Datapath/index fields still capture ID inputs; their values are don't-care.
  - normal: capture all ID inputs; ex_valid=id_valid.
- Control sanitizing on capture:
  - If id_valid=0, all control outputs are stored as 0.
  - ex_mem_to_reg is stored as id_mem_to_reg & id_reg_write, so an X driven by decode for store/branch never propagates.
  - All control inputs are treated as 0 when id_valid=0.
- stall_count increments on each cycle with stall=1. flush_count increments on each cycle with flush=1. Both saturate at all-ones and never wrap.

## Timing
- Capture latency is 1 cycle: ID values on edge N appear on ex_* after edge N.
- stall is combinational from registered ex_* state plus current id_* inputs. No path from flush to ex_* except through registers.
- A load followed by a dependent instruction gives exactly one stall cycle. On the next edge ex_mem_read=0 (bubble), so stall drops; the held instruction then enters EX, and forwarding from MEM/WB covers it.
- Back-to-back loads with a dependency between them give one stall per dependent pair.
- Reset asserted mid-stall: the next edge clears ex_valid, which forces stall=0 in the same cycle after reset. Counters clear to 0.
- Flush and hazard in the same cycle: stall=0, one bubble, flush_count+1, stall_count unchanged.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants (R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011, OPIMM 0010011)
  - ALUOp encodings (00 add, 01 branch compare, 10 funct-decoded)
  - packed struct `ctrl_t` holding the seven control bits
  - `CTRL_NOP` constant (all zero)
- One combinational sub-module `load_use_detector` (ex_mem_read, ex_valid, ex_rd, id_valid, id_rs1, id_rs2, uses_rs2 → hazard). Registers and counters stay in id_ex_stage.

## Test plan
- Reset, then feed R-type add (rs1=1, rs2=2, rd=3, id_valid=1) → after one edge: ex_reg_write=1, ex_alu_op=10, ex_alu_src=0, ex_rd=3, ex_valid=1, stall=0.
- Load rd=5, then add rs1=5 → stall=1 for exactly one cycle; EX gets a bubble (ex_valid=0, controls 0); the add appears in EX on the following edge; stall_count=1.
- Load rd=5, then addi with rs1=6 and imm bits making id_rs2=5 → no stall. Load rd=0, then add rs1=0 → no stall.
- Store with id_mem_to_reg=X, id_reg_write=0 → ex_mem_to_reg=0 (not X), ex_mem_write=1, ex_alu_src=1.
- Load-use hazard with flush=1 in the same cycle → stall=0, bubble in EX, flush_count=1, stall_count=0. Assert reset during a stall → all outputs 0 on the next edge.
- Force stall_count to all-ones via a long stall sequence (CNT_W=4 for the test) → it holds at 15 on further stalls.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline:
// opcodes, ALUOp encodings and the decode control bundle.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard check between the load in EX
// and the instruction currently in ID.
module load_use_detector
    import riscv_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic       ex_valid,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       uses_rs2,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = (ex_rd == id_rs1);
    assign rs2_hit = uses_rs2 & (ex_rd == id_rs2);

    assign hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0)
                  & id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles
// and saturating stall/flush event counters.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [1:0]       id_alu_op,
    input  logic             id_branch,
    input  logic             id_mem_read,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [3:0]       id_funct,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [1:0]       ex_alu_op,
    output logic             ex_branch,
    output logic             ex_mem_read,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_reg_write,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_funct,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  uses_rs2;
    logic  hazard;
    logic  bubble;

    // Decode may drive X on mem_to_reg for stores/branches; mask it here.
    always_comb begin
        id_ctrl = CTRL_NOP;
        if (id_valid) begin
            id_ctrl.alu_op     = id_alu_op;
            id_ctrl.branch     = id_branch;
            id_ctrl.mem_read   = id_mem_read;
            id_ctrl.mem_to_reg = id_mem_to_reg & id_reg_write;
            id_ctrl.mem_write  = id_mem_write;
            id_ctrl.alu_src    = id_alu_src;
            id_ctrl.reg_write  = id_reg_write;
        end
    end

    assign uses_rs2 = ~id_alu_src | id_mem_write;

    load_use_detector u_detect (
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .uses_rs2    (uses_rs2),
        .hazard      (hazard)
    );

    assign stall  = hazard & ~flush;
    assign bubble = flush | stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= CTRL_NOP;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
        end else begin
            ex_valid    <= bubble ? 1'b0 : id_valid;
            ex_ctrl     <= bubble ? CTRL_NOP : id_ctrl;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            if (flush && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

    assign ex_alu_op     = ex_ctrl.alu_op;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_reg_write  = ex_ctrl.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: capture, load-use stall,
// flush priority, control sanitizing, reset and counter saturation.
module tb_id_ex_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [1:0]       id_alu_op;
    logic             id_branch, id_mem_read, id_mem_to_reg;
    logic             id_mem_write, id_alu_src, id_reg_write;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [3:0]       id_funct;
    logic             flush;
    logic             stall;
    logic             ex_valid;
    logic [1:0]       ex_alu_op;
    logic             ex_branch, ex_mem_read, ex_mem_to_reg;
    logic             ex_mem_write, ex_alu_src, ex_reg_write;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [3:0]       ex_funct;
    logic [CNT_W-1:0] stall_count, flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_alu_op(id_alu_op), .id_branch(id_branch),
        .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_funct(id_funct), .flush(flush),
        .stall(stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct(ex_funct), .stall_count(stall_count),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic v, input logic [1:0] op,
                            input logic br, input logic mr,
                            input logic m2r, input logic mw,
                            input logic as, input logic rw);
        id_valid      = v;
        id_alu_op     = op;
        id_branch     = br;
        id_mem_read   = mr;
        id_mem_to_reg = m2r;
        id_mem_write  = mw;
        id_alu_src    = as;
        id_reg_write  = rw;
    endtask

    task automatic set_regs(input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [63:0] pc);
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_pc       = pc;
        id_rs1_data = pc + 64'h1000;
        id_rs2_data = pc + 64'h2000;
        id_imm      = 64'h0;
        id_funct    = 4'h0;
    endtask

    task automatic set_rtype(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd);
        set_ctrl(1'b1, 2'b10, 0, 0, 0, 0, 0, 1);
        set_regs(rs1, rs2, rd, 64'h100);
    endtask

    task automatic set_load(input logic [4:0] rs1, input logic [4:0] rd);
        set_ctrl(1'b1, 2'b00, 0, 1, 1, 0, 1, 1);
        set_regs(rs1, 5'd0, rd, 64'h200);
    endtask

    // addi whose imm bits alias onto the rs2 field
    task automatic set_addi(input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd);
        set_ctrl(1'b1, 2'b10, 0, 0, 0, 0, 1, 1);
        set_regs(rs1, rs2, rd, 64'h300);
        id_imm = {59'd0, rs2};
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_ctrl(0, 2'b00, 0, 0, 0, 0, 0, 0);
        set_regs(0, 0, 0, 64'h0);
        tick();
        tick();
        check("rst_valid", ex_valid, 0);
        check("rst_regw", ex_reg_write, 0);
        check("rst_pc", ex_pc, 0);
        check("rst_scnt", stall_count, 0);
        check("rst_fcnt", flush_count, 0);
        reset = 1'b0;

        set_rtype(1, 2, 3);
        #1 check("add_nostall", stall, 0);
        tick();
        check("add_valid", ex_valid, 1);
        check("add_regw", ex_reg_write, 1);
        check("add_aluop", ex_alu_op, 2'b10);
        check("add_alusrc", ex_alu_src, 0);
        check("add_rd", ex_rd, 3);
        check("add_pc", ex_pc, 64'h100);
        check("add_stall", stall, 0);

        set_load(1, 5);
        tick();
        check("ld_mr", ex_mem_read, 1);
        set_rtype(5, 2, 6);
        #1 check("lu_stall", stall, 1);
        tick();
        check("lu_bub_valid", ex_valid, 0);
        check("lu_bub_regw", ex_reg_write, 0);
        check("lu_bub_aluop", ex_alu_op, 0);
        check("lu_stall_drop", stall, 0);
        check("lu_scnt", stall_count, 1);
        tick();
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_rd", ex_rd, 6);
        check("lu_add_regw", ex_reg_write, 1);
        check("lu_scnt_hold", stall_count, 1);

        set_load(1, 5);
        tick();
        set_addi(6, 5, 7);
        #1 check("addi_no_rs2", stall, 0);
        tick();
        set_load(1, 0);
        tick();
        set_rtype(0, 2, 8);
        #1 check("x0_nostall", stall, 0);
        tick();
        set_load(1, 5);
        tick();
        set_rtype(2, 5, 9);
        #1 check("rs2_stall", stall, 1);
        tick();
        check("rs2_scnt", stall_count, 2);

        set_ctrl(1'b1, 2'b00, 0, 0, 1'bx, 1, 1, 0);
        set_regs(1, 2, 0, 64'h400);
        tick();
        check("st_m2r", ex_mem_to_reg, 0);
        check("st_mw", ex_mem_write, 1);
        check("st_alusrc", ex_alu_src, 1);
        check("st_regw", ex_reg_write, 0);

        set_rtype(1, 2, 3);
        id_valid = 1'b0;
        tick();
        check("inv_valid", ex_valid, 0);
        check("inv_regw", ex_reg_write, 0);
        check("inv_aluop", ex_alu_op, 0);

        set_load(1, 5);
        tick();
        set_rtype(5, 2, 6);
        flush = 1'b1;
        #1 check("fl_stall", stall, 0);
        tick();
        flush = 1'b0;
        check("fl_valid", ex_valid, 0);
        check("fl_regw", ex_reg_write, 0);
        check("fl_fcnt", flush_count, 1);
        check("fl_scnt", stall_count, 2);

        set_load(1, 5);
        tick();
        set_rtype(5, 2, 6);
        #1 check("rs_pre_stall", stall, 1);
        reset = 1'b1;
        tick();
        check("rs_valid", ex_valid, 0);
        check("rs_stall", stall, 0);
        check("rs_scnt", stall_count, 0);
        check("rs_fcnt", flush_count, 0);
        check("rs_rd", ex_rd, 0);
        check("rs_pc", ex_pc, 0);
        reset = 1'b0;

        // ld x5,0(x5) repeated: stall on every other edge
        set_load(5, 5);
        repeat (40) tick();
        check("sat_scnt", stall_count, 15);
        repeat (6) tick();
        check("sat_scnt_hold", stall_count, 15);

        flush = 1'b1;
        repeat (20) tick();
        flush = 1'b0;
        check("sat_fcnt", flush_count, 15);
        check("sat_scnt_fl", stall_count, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
